// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_stage
// Purpose  : Writeback/commit stage. Retires one MS entry per cycle, folds
//            exceptions/ERET/TLB refetch into one flush, sequences TLB ops.
// Revision : 1.0
// ============================================================================
module wb_commit_stage #(
    parameter int         TLBNUM         = 16,
    parameter int         TLB_OP_LAT     = 2,
    parameter int         CNT_W          = 32,
    parameter logic [4:0] NO_EX          = 5'h1f,
    parameter logic [4:0] INT_CODE       = 5'h00,
    parameter logic [4:0] CP0_EPC_ADDR   = 5'd14,
    parameter logic [4:0] CP0_INDEX_ADDR = 5'd0,
    parameter int         IDX_W          = $clog2(TLBNUM)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ms_to_ws_valid,
    output logic             ws_allowin,
    input  logic [31:0]      ms_pc,
    input  logic [31:0]      ms_result,
    input  logic             ms_gr_we,
    input  logic [4:0]       ms_dest,
    input  logic [4:0]       ms_ex_code,
    input  logic             ms_pc_error,
    input  logic [31:0]      ms_badvaddr,
    input  logic             ms_slot,
    input  logic             ms_eret,
    input  logic             ms_mfc0,
    input  logic             ms_mtc0,
    input  logic             ms_tlbwi,
    input  logic             ms_tlbr,
    input  logic [4:0]       ms_cp0_addr,
    input  logic             int_pending,
    input  logic [31:0]      cp0_rdata,
    output logic [4:0]       cp0_raddr,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [4:0]       fwd_dest,
    output logic [31:0]      fwd_data,
    output logic             fwd_mfc0,
    output logic             ws_ex,
    output logic [4:0]       ws_ex_code,
    output logic [31:0]      ws_epc_wdata,
    output logic             ws_slot_o,
    output logic             ws_eret,
    output logic [31:0]      ws_epc,
    output logic             ws_mtc0_we,
    output logic             tlb_we,
    output logic             tlb_re,
    output logic [IDX_W-1:0] tlb_index,
    output logic             ws_flush,
    output logic             ws_refetch,
    output logic [31:0]      ws_refetch_pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_wen,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
);

    // Counter only ever holds TLB_OP_LAT-1 down to 0.
    localparam int             c_LAT_W    = (TLB_OP_LAT > 1) ? $clog2(TLB_OP_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_INIT = c_LAT_W'(TLB_OP_LAT - 1);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_TLB_WAIT = 1'b1;

    logic [0:0]         r_state, w_state_nxt;
    logic [c_LAT_W-1:0] r_lat_cnt, w_lat_cnt_nxt;
    logic [CNT_W-1:0]   r_retire_cnt;

    logic        r_ws_valid;
    logic [31:0] r_pc, r_result, r_badvaddr;
    logic        r_gr_we, r_pc_error, r_slot, r_eret, r_mfc0, r_mtc0, r_tlbwi, r_tlbr;
    logic [4:0]  r_dest, r_ex_code, r_cp0_addr;

    logic w_ex_taken, w_tlb_op, w_tlb_issue, w_ready_go, w_refetch;
    logic w_eret, w_flush, w_allowin, w_rf_we;

    assign w_ex_taken = r_ws_valid && (r_state == S_IDLE) &&
                        (int_pending || (r_ex_code != NO_EX));
    assign w_tlb_op   = r_ws_valid && (r_tlbwi || r_tlbr) && !w_ex_taken;
    assign w_eret     = r_ws_valid && r_eret && !w_ex_taken;
    assign w_flush    = w_ex_taken || w_eret || w_refetch;
    assign w_allowin  = !r_ws_valid || (w_ready_go && !w_flush);
    assign w_rf_we    = r_ws_valid && r_gr_we && !w_ex_taken && w_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_lat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_ready_go    = 1'b1;
        w_tlb_issue   = 1'b0;
        w_refetch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tlb_op) begin
                    w_tlb_issue = 1'b1;
                    if (TLB_OP_LAT == 0) begin
                        w_refetch = 1'b1;
                    end else begin
                        w_ready_go    = 1'b0;
                        w_state_nxt   = S_TLB_WAIT;
                        w_lat_cnt_nxt = c_LAT_INIT;
                    end
                end
            end
            S_TLB_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_refetch   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ready_go    = 1'b0;
                    w_lat_cnt_nxt = r_lat_cnt - c_LAT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A flushing entry leaves WB even though the stage refuses new input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ws_valid   <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            if (w_flush)
                r_ws_valid <= 1'b0;
            else if (w_allowin)
                r_ws_valid <= ms_to_ws_valid;
            if (r_ws_valid && w_ready_go && !w_ex_taken)
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc <= '0; r_result <= '0; r_badvaddr <= '0;
            r_gr_we <= 1'b0; r_pc_error <= 1'b0; r_slot <= 1'b0; r_eret <= 1'b0;
            r_mfc0 <= 1'b0; r_mtc0 <= 1'b0; r_tlbwi <= 1'b0; r_tlbr <= 1'b0;
            r_dest <= '0; r_ex_code <= NO_EX; r_cp0_addr <= '0;
        end else if (ms_to_ws_valid && w_allowin) begin
            r_pc <= ms_pc; r_result <= ms_result; r_badvaddr <= ms_badvaddr;
            r_gr_we <= ms_gr_we; r_pc_error <= ms_pc_error; r_slot <= ms_slot;
            r_eret <= ms_eret; r_mfc0 <= ms_mfc0; r_mtc0 <= ms_mtc0;
            r_tlbwi <= ms_tlbwi; r_tlbr <= ms_tlbr;
            r_dest <= ms_dest; r_ex_code <= ms_ex_code; r_cp0_addr <= ms_cp0_addr;
        end
    end

    always_comb begin
        cp0_raddr = CP0_INDEX_ADDR;
        if (r_ws_valid && r_eret)
            cp0_raddr = CP0_EPC_ADDR;
        else if (r_ws_valid && r_mfc0)
            cp0_raddr = r_cp0_addr;
    end

    assign ws_allowin        = w_allowin;
    assign rf_we             = w_rf_we;
    assign rf_waddr          = r_dest;
    assign rf_wdata          = r_mfc0 ? cp0_rdata : r_result;
    assign fwd_dest          = r_ws_valid ? r_dest : 5'd0;
    assign fwd_data          = rf_wdata;
    assign fwd_mfc0          = r_ws_valid && r_mfc0;
    assign ws_ex             = w_ex_taken;
    assign ws_ex_code        = int_pending ? INT_CODE : r_ex_code;
    assign ws_epc_wdata      = r_pc_error ? r_badvaddr : r_pc;
    assign ws_slot_o         = r_slot;
    assign ws_eret           = w_eret;
    assign ws_epc            = cp0_rdata;
    assign ws_mtc0_we        = r_ws_valid && r_mtc0 && !w_ex_taken;
    assign tlb_we            = w_tlb_issue && r_tlbwi;
    assign tlb_re            = w_tlb_issue && r_tlbr;
    assign tlb_index         = cp0_rdata[IDX_W-1:0];
    assign ws_flush          = w_flush;
    assign ws_refetch        = w_refetch;
    assign ws_refetch_pc     = r_pc + 32'd4;
    assign retire_cnt        = r_retire_cnt;
    assign debug_wb_pc       = r_pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_dest;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_stage
// Purpose  : Directed + randomized bench for wb_commit_stage against a
//            transaction-level commit model.
// Revision : 1.0
// ============================================================================
module tb_wb_commit_stage;

    localparam int         c_LAT   = 2;
    localparam int         c_CNT_W = 4;
    localparam logic [4:0] c_NO_EX = 5'h1f;
    localparam logic [4:0] c_INT   = 5'h00;
    localparam logic [4:0] c_EPC_A = 5'd14;
    localparam logic [4:0] c_IDX_A = 5'd0;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ms_to_ws_valid, ws_allowin;
    logic [31:0] ms_pc, ms_result, ms_badvaddr;
    logic        ms_gr_we, ms_pc_error, ms_slot, ms_eret, ms_mfc0, ms_mtc0, ms_tlbwi, ms_tlbr;
    logic [4:0]  ms_dest, ms_ex_code, ms_cp0_addr;
    logic        int_pending;
    logic [31:0] cp0_rdata;
    logic [4:0]  cp0_raddr;
    logic        rf_we;
    logic [4:0]  rf_waddr, fwd_dest, ws_ex_code;
    logic [31:0] rf_wdata, fwd_data, ws_epc_wdata, ws_epc, ws_refetch_pc;
    logic        fwd_mfc0, ws_ex, ws_slot_o, ws_eret, ws_mtc0_we, tlb_we, tlb_re;
    logic [3:0]  tlb_index;
    logic        ws_flush, ws_refetch;
    logic [c_CNT_W-1:0] retire_cnt;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    always #5 clk = ~clk;

    wb_commit_stage #(.TLBNUM(16), .TLB_OP_LAT(c_LAT), .CNT_W(c_CNT_W)) dut (
        .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
        .ms_ex_code(ms_ex_code), .ms_pc_error(ms_pc_error), .ms_badvaddr(ms_badvaddr),
        .ms_slot(ms_slot), .ms_eret(ms_eret), .ms_mfc0(ms_mfc0), .ms_mtc0(ms_mtc0),
        .ms_tlbwi(ms_tlbwi), .ms_tlbr(ms_tlbr), .ms_cp0_addr(ms_cp0_addr),
        .int_pending(int_pending), .cp0_rdata(cp0_rdata), .cp0_raddr(cp0_raddr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .fwd_mfc0(fwd_mfc0), .ws_ex(ws_ex), .ws_ex_code(ws_ex_code),
        .ws_epc_wdata(ws_epc_wdata), .ws_slot_o(ws_slot_o), .ws_eret(ws_eret), .ws_epc(ws_epc),
        .ws_mtc0_we(ws_mtc0_we), .tlb_we(tlb_we), .tlb_re(tlb_re), .tlb_index(tlb_index),
        .ws_flush(ws_flush), .ws_refetch(ws_refetch), .ws_refetch_pc(ws_refetch_pc),
        .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct {
        logic [31:0] pc, result, badvaddr;
        logic        gr_we, pc_error, slot, eret, mfc0, mtc0, tlbwi, tlbr;
        logic [4:0]  dest, ex_code, cp0_addr;
    } entry_t;

    // Model: the instruction held in WB, cycles left on its TLB op, retired count.
    entry_t      m_e;
    bit          m_valid;
    int          m_left;
    int unsigned m_cnt;
    bit          x_flush, x_allowin, x_commit, x_stall, x_issue;
    bit          in_v;
    entry_t      in_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest);
        entry_t e;
        e.pc = pc; e.result = res; e.badvaddr = 32'h0; e.dest = dest;
        e.gr_we = 1'b1; e.pc_error = 1'b0; e.slot = 1'b0; e.eret = 1'b0; e.mfc0 = 1'b0;
        e.mtc0 = 1'b0; e.tlbwi = 1'b0; e.tlbr = 1'b0; e.ex_code = c_NO_EX; e.cp0_addr = 5'd0;
        return e;
    endfunction

    function automatic entry_t rnd_entry();
        entry_t e;
        int k;
        e = mk($urandom & 32'hffff_fffc, $urandom, 5'($urandom));
        e.badvaddr = $urandom;
        e.gr_we    = ($urandom_range(0, 3) != 0);
        e.pc_error = 1'($urandom);
        e.slot     = 1'($urandom);
        e.cp0_addr = 5'($urandom);
        e.ex_code  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 30)) : c_NO_EX;
        k = $urandom_range(0, 11);
        e.eret = (k == 0); e.mfc0 = (k == 1); e.mtc0 = (k == 2); e.tlbwi = (k == 3); e.tlbr = (k == 4);
        return e;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_left = 0; m_cnt = 0;
    endtask

    task automatic step_begin(input bit v, input entry_t e, input bit irq, input logic [31:0] rd);
        bit ex, eret, refetch, mtc0, rfwe, tw, tr;
        logic [4:0] raddr;
        ms_to_ws_valid = v; ms_pc = e.pc; ms_result = e.result; ms_badvaddr = e.badvaddr;
        ms_gr_we = e.gr_we; ms_pc_error = e.pc_error; ms_slot = e.slot; ms_eret = e.eret;
        ms_mfc0 = e.mfc0; ms_mtc0 = e.mtc0; ms_tlbwi = e.tlbwi; ms_tlbr = e.tlbr;
        ms_dest = e.dest; ms_ex_code = e.ex_code; ms_cp0_addr = e.cp0_addr;
        int_pending = irq; cp0_rdata = rd;
        in_v = v; in_e = e;
        #1;
        ex = 0; eret = 0; refetch = 0; mtc0 = 0; rfwe = 0; tw = 0; tr = 0; raddr = c_IDX_A;
        x_commit = 0; x_stall = 0; x_issue = 0;
        if (m_valid) begin
            if (m_e.eret) raddr = c_EPC_A;
            else if (m_e.mfc0) raddr = m_e.cp0_addr;
            if (m_left > 0) begin
                if (m_left == 1) begin refetch = 1; x_commit = 1; end
                else x_stall = 1;
            end else if (irq || m_e.ex_code != c_NO_EX) begin
                ex = 1;
            end else if (m_e.tlbwi || m_e.tlbr) begin
                x_issue = 1; tw = m_e.tlbwi; tr = m_e.tlbr;
                if (c_LAT == 0) begin refetch = 1; x_commit = 1; end
                else x_stall = 1;
            end else begin
                x_commit = 1; eret = m_e.eret; mtc0 = m_e.mtc0;
            end
            rfwe = x_commit && m_e.gr_we;
        end
        x_flush   = ex || eret || refetch;
        x_allowin = !m_valid || (!x_stall && !x_flush);

        chk("allowin", ws_allowin, x_allowin);
        chk("flush", ws_flush, x_flush);
        chk("ex", ws_ex, ex);
        chk("eret", ws_eret, eret);
        chk("refetch", ws_refetch, refetch);
        chk("mtc0_we", ws_mtc0_we, mtc0);
        chk("tlb_we", tlb_we, tw);
        chk("tlb_re", tlb_re, tr);
        chk("rf_we", rf_we, rfwe);
        chk("dbg_wen", debug_wb_rf_wen, {4{rfwe}});
        chk("retire_cnt", retire_cnt, m_cnt % 16);
        chk("cp0_raddr", cp0_raddr, raddr);
        chk("fwd_dest", fwd_dest, m_valid ? m_e.dest : 5'd0);
        chk("fwd_mfc0", fwd_mfc0, m_valid && m_e.mfc0);
        if (rfwe) begin
            chk("rf_waddr", rf_waddr, m_e.dest);
            chk("rf_wdata", rf_wdata, m_e.mfc0 ? rd : m_e.result);
            chk("fwd_data", fwd_data, m_e.mfc0 ? rd : m_e.result);
            chk("dbg_wnum", debug_wb_rf_wnum, m_e.dest);
            chk("dbg_wdata", debug_wb_rf_wdata, m_e.mfc0 ? rd : m_e.result);
            chk("dbg_pc", debug_wb_pc, m_e.pc);
        end
        if (ex) begin
            chk("ex_code", ws_ex_code, irq ? c_INT : m_e.ex_code);
            chk("epc_wdata", ws_epc_wdata, m_e.pc_error ? m_e.badvaddr : m_e.pc);
            chk("slot", ws_slot_o, m_e.slot);
        end
        if (eret)    chk("ws_epc", ws_epc, rd);
        if (refetch) chk("refetch_pc", ws_refetch_pc, m_e.pc + 32'd4);
        if (x_issue) chk("tlb_index", tlb_index, rd & 32'hf);
    endtask

    task automatic step_end();
        if (x_commit) m_cnt++;
        if (x_flush) begin
            m_valid = 1'b0; m_left = 0;
        end else begin
            if (x_issue) m_left = c_LAT;
            else if (m_left > 0) m_left--;
            if (x_allowin) begin
                m_valid = in_v; m_e = in_e; m_left = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit v, input entry_t e, input bit irq, input logic [31:0] rd);
        step_begin(v, e, irq, rd);
        step_end();
    endtask

    entry_t idle, e;

    initial begin
        idle = mk(32'h0, 32'h0, 5'd0);
        idle.gr_we = 1'b0;
        resetn = 1'b0;
        ms_to_ws_valid = 1'b0; ms_pc = 0; ms_result = 0; ms_badvaddr = 0; ms_gr_we = 0;
        ms_pc_error = 0; ms_slot = 0; ms_eret = 0; ms_mfc0 = 0; ms_mtc0 = 0; ms_tlbwi = 0;
        ms_tlbr = 0; ms_dest = 0; ms_ex_code = c_NO_EX; ms_cp0_addr = 0;
        int_pending = 0; cp0_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_retire", retire_cnt, 0);
        chk("rst_allowin", ws_allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flush", ws_flush, 0);
        chk("rst_dbg_pc", debug_wb_pc, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Plain ALU commit
        cyc(1, mk(32'hbfc00000, 32'h1234, 5'd8), 0, 0);
        step_begin(0, idle, 0, 0);
        chk("addu_we", rf_we, 1);
        chk("addu_waddr", rf_waddr, 8);
        chk("addu_wdata", rf_wdata, 32'h1234);
        chk("addu_dbg_wen", debug_wb_rf_wen, 4'hf);
        step_end();
        step_begin(0, idle, 0, 0);
        chk("addu_retire", retire_cnt, 1);
        step_end();

        // Exception with PC fault
        e = mk(32'hbfc00010, 32'h55, 5'd3);
        e.ex_code = 5'h04; e.pc_error = 1'b1; e.badvaddr = 32'h80000003;
        cyc(1, e, 0, 0);
        step_begin(0, idle, 0, 0);
        chk("exc_ex", ws_ex, 1);
        chk("exc_epc", ws_epc_wdata, 32'h80000003);
        chk("exc_rf_we", rf_we, 0);
        chk("exc_flush", ws_flush, 1);
        chk("exc_retire", retire_cnt, 1);
        step_end();
        step_begin(0, idle, 0, 0);
        chk("exc_cleared", ws_allowin, 1);
        step_end();

        // Interrupt on a normal entry
        cyc(1, mk(32'h100, 32'h77, 5'd9), 0, 0);
        step_begin(0, idle, 1, 0);
        chk("int_code", ws_ex_code, 5'h00);
        chk("int_epc", ws_epc_wdata, 32'h100);
        chk("int_rf_we", rf_we, 0);
        step_end();

        // TLBWI with a two-cycle hold; a waiting MS entry must not sneak in
        e = mk(32'hbfc00100, 32'h0, 5'd0);
        e.tlbwi = 1'b1; e.gr_we = 1'b0;
        cyc(1, e, 0, 0);
        step_begin(1, mk(32'hbfc00104, 32'h99, 5'd4), 0, 32'h5);
        chk("tlbwi_we", tlb_we, 1);
        chk("tlbwi_index", tlb_index, 5);
        chk("tlbwi_hold1", ws_allowin, 0);
        step_end();
        step_begin(1, mk(32'hbfc00104, 32'h99, 5'd4), 0, 32'h5);
        chk("tlbwi_hold2", ws_allowin, 0);
        chk("tlbwi_we_once", tlb_we, 0);
        step_end();
        step_begin(1, mk(32'hbfc00104, 32'h99, 5'd4), 1, 32'h0);
        chk("tlbwi_refetch", ws_refetch, 1);
        chk("tlbwi_rpc", ws_refetch_pc, 32'hbfc00104);
        step_end();
        step_begin(0, idle, 0, 0);
        chk("tlbwi_retire", retire_cnt, 2);
        step_end();

        // ERET with a simultaneous incoming entry
        e = mk(32'hbfc00200, 32'h0, 5'd0);
        e.eret = 1'b1; e.gr_we = 1'b0;
        cyc(1, e, 0, 0);
        step_begin(1, mk(32'hbfc00204, 32'h11, 5'd6), 0, 32'hbfc00380);
        chk("eret_pulse", ws_eret, 1);
        chk("eret_epc", ws_epc, 32'hbfc00380);
        chk("eret_flush", ws_flush, 1);
        chk("eret_raddr", cp0_raddr, 5'd14);
        chk("eret_noaccept", ws_allowin, 0);
        step_end();
        step_begin(0, idle, 0, 0);
        chk("eret_dropped", rf_we, 0);
        chk("eret_retire", retire_cnt, 3);
        step_end();

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, rnd_entry(), $urandom_range(0, 11) == 0, $urandom);
        repeat (6) cyc(0, idle, 0, 0);

        // Reset during TLB_WAIT
        e = mk(32'h80001000, 32'h0, 5'd0);
        e.tlbr = 1'b1; e.gr_we = 1'b0;
        cyc(1, e, 0, 0);
        cyc(0, idle, 0, 32'h3);
        resetn = 1'b0;
        #1;
        chk("rstw_refetch", ws_refetch, 0);
        chk("rstw_allowin", ws_allowin, 1);
        chk("rstw_retire", retire_cnt, 0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (3) cyc(0, idle, 0, 0);

        // Counter wrap: 17 retirements on a 4-bit counter
        for (int i = 0; i < 17; i++)
            cyc(1, mk(32'h1000 + 32'(i * 4), 32'(i), 5'(i + 1)), 0, 0);
        repeat (2) cyc(0, idle, 0, 0);
        chk("wrap_retire", retire_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
